// File: rtl/jt49_env_gen_if.sv
// Envelope generator control/status bundle: register-file side drives the
// rate enable, period, shape and restart; the envelope side returns level and busy.
interface jt49_env_gen_if #(
  parameter int PW = 16
);
  logic          cen256;
  logic [PW-1:0] period;
  logic [3:0]    shape;
  logic          restart;
  logic [4:0]    env;
  logic          busy;

  modport master (
    output cen256, period, shape, restart,
    input  env, busy
  );

  modport slave (
    input  cen256, period, shape, restart,
    output env, busy
  );
endinterface

// File: rtl/jt49_env_gen.sv
// AY-3-8910 style envelope generator: period counter, 32-step ramp and the
// CONT/ATT/ALT/HOLD end-of-cycle behaviour, with registered level and busy.
module jt49_env_gen #(
  parameter int PW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  jt49_env_gen_if.slave    bus
);

  logic [PW-1:0] cnt_r, cnt_s;
  logic [4:0]    step_r, step_s;
  logic          inv_r, inv_s;
  logic          held_r, held_s;
  logic [4:0]    env_r, env_s;
  logic          busy_r;
  logic [PW-1:0] per_s;
  logic          cont_s, att_s, alt_s, hold_s;
  logic          tick_s;

  function automatic logic [4:0] level_f(input logic [4:0] s, input logic iv, input logic att);
    logic [4:0] base;
    base = att ? s : (5'd31 - s);
    return iv ? (5'd31 - base) : base;
  endfunction

  assign cont_s = bus.shape[3];
  assign att_s  = bus.shape[2];
  assign alt_s  = bus.shape[1];
  assign hold_s = bus.shape[0];

  // A zero period behaves like one so the envelope never stalls.
  assign per_s  = (bus.period == {PW{1'b0}}) ? {{(PW-1){1'b0}}, 1'b1} : bus.period;
  assign tick_s = ({1'b0, cnt_r} + {{PW{1'b0}}, 1'b1}) >= {1'b0, per_s};

  // Next-state and next-level computation for one clk cycle.
  always_comb begin
    cnt_s  = cnt_r;
    step_s = step_r;
    inv_s  = inv_r;
    held_s = held_r;
    env_s  = env_r;
    if (bus.restart) begin
      cnt_s  = {PW{1'b0}};
      step_s = 5'd0;
      inv_s  = 1'b0;
      held_s = 1'b0;
      env_s  = level_f(5'd0, 1'b0, att_s);
    end else if (bus.cen256 && !held_r) begin
      if (tick_s) begin
        cnt_s = {PW{1'b0}};
        if (step_r == 5'd31) begin
          if (!cont_s) begin
            held_s = 1'b1;
            env_s  = 5'd0;
          end else if (hold_s) begin
            // Freeze on the cycle's end level, flipped when ALT is set.
            held_s = 1'b1;
            inv_s  = inv_r ^ alt_s;
            env_s  = level_f(step_r, inv_r ^ alt_s, att_s);
          end else begin
            step_s = 5'd0;
            inv_s  = inv_r ^ alt_s;
            env_s  = level_f(5'd0, inv_r ^ alt_s, att_s);
          end
        end else begin
          step_s = step_r + 5'd1;
          env_s  = level_f(step_r + 5'd1, inv_r, att_s);
        end
      end else begin
        cnt_s = cnt_r + {{(PW-1){1'b0}}, 1'b1};
        env_s = level_f(step_r, inv_r, att_s);
      end
    end else if (!held_r) begin
      env_s = level_f(step_r, inv_r, att_s);
    end else begin
      env_s = env_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r  <= {PW{1'b0}};
      step_r <= 5'd0;
      inv_r  <= 1'b0;
      held_r <= 1'b1;
      env_r  <= 5'd0;
      busy_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_s;
      step_r <= step_s;
      inv_r  <= inv_s;
      held_r <= held_s;
      env_r  <= env_s;
      busy_r <= !held_s;
    end
  end

  assign bus.env  = env_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_jt49_env_gen.sv
// Directed self-checking bench for jt49_env_gen: decay, triangle, hold shapes,
// period-zero equivalence, live shape change and restart/reset priority.
module tb_jt49_env_gen;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  jt49_env_gen_if #(.PW(16)) bus ();

  jt49_env_gen #(.PW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [4:0] e_exp, input logic b_exp);
    n_checks++;
    if (bus.env !== e_exp || bus.busy !== b_exp) begin
      n_fail++;
      $display("FAIL %s: env=%0d busy=%0b, required env=%0d busy=%0b",
               name, bus.env, bus.busy, e_exp, b_exp);
    end
  endtask

  task automatic cen_pulse();
    @(negedge clk);
    bus.cen256 = 1'b1;
    @(negedge clk);
    bus.cen256 = 1'b0;
  endtask

  task automatic do_restart();
    @(negedge clk);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.cen256  = 1'b0;
    bus.restart = 1'b0;
    bus.period  = 16'd1;
    bus.shape   = 4'b1100;
    idle(2);
    chk("reset_state", 5'd0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cen_pulse();
      if (i == 50) begin
        do_restart();
      end
      chk("reset_hold", 5'd0, 1'b0);
      idle(2);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cen_pulse();
      chk("no_move_before_restart", 5'd0, 1'b0);
    end
  endtask

  task automatic test_decay();
    bus.period = 16'd1;
    bus.shape  = 4'b0000;
    do_restart();
    chk("decay_start", 5'd31, 1'b1);
    for (int i = 1; i <= 31; i++) begin
      cen_pulse();
      chk("decay_ramp", 5'(31 - i), 1'b1);
    end
    cen_pulse();
    chk("decay_end", 5'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cen_pulse();
      chk("decay_held", 5'd0, 1'b0);
    end
  endtask

  task automatic test_triangle();
    int s;
    int p;
    bus.period = 16'd3;
    bus.shape  = 4'b1110;
    do_restart();
    chk("tri_start", 5'd0, 1'b1);
    for (int k = 1; k <= 192; k++) begin
      cen_pulse();
      s = k / 3;
      p = s % 64;
      chk("tri_ramp", (p < 32) ? 5'(p) : 5'(63 - p), 1'b1);
    end
  endtask

  task automatic test_period_zero();
    logic [4:0] tr0 [128];
    bus.shape  = 4'b1100;
    bus.period = 16'd0;
    do_restart();
    for (int k = 0; k < 128; k++) begin
      cen_pulse();
      tr0[k] = bus.env;
    end
    bus.period = 16'd1;
    do_restart();
    for (int k = 0; k < 128; k++) begin
      cen_pulse();
      chk("saw_p1", 5'((k + 1) % 32), 1'b1);
      n_checks++;
      if (tr0[k] !== 5'((k + 1) % 32)) begin
        n_fail++;
        $display("FAIL saw_p0: env=%0d, required env=%0d at pulse %0d", tr0[k], (k + 1) % 32, k + 1);
      end
    end
  endtask

  task automatic test_hold();
    bus.period = 16'd1;
    bus.shape  = 4'b1011;
    do_restart();
    chk("h1011_start", 5'd31, 1'b1);
    for (int i = 1; i <= 31; i++) begin
      cen_pulse();
      chk("h1011_ramp", 5'(31 - i), 1'b1);
    end
    cen_pulse();
    chk("h1011_end", 5'd31, 1'b0);
    cen_pulse();
    chk("h1011_held", 5'd31, 1'b0);
    bus.shape = 4'b1101;
    do_restart();
    chk("h1101_start", 5'd0, 1'b1);
    for (int i = 1; i <= 31; i++) begin
      cen_pulse();
      chk("h1101_ramp", 5'(i), 1'b1);
    end
    cen_pulse();
    chk("h1101_end", 5'd31, 1'b0);
    cen_pulse();
    chk("h1101_held", 5'd31, 1'b0);
  endtask

  task automatic test_shape_live();
    bus.period = 16'd1;
    bus.shape  = 4'b1100;
    do_restart();
    for (int i = 0; i < 5; i++) cen_pulse();
    chk("live_before", 5'd5, 1'b1);
    @(negedge clk);
    bus.shape = 4'b1000;
    @(negedge clk);
    chk("live_att_off", 5'd26, 1'b1);
  endtask

  task automatic test_restart_collision();
    bus.period = 16'd1;
    bus.shape  = 4'b1100;
    do_restart();
    for (int i = 0; i < 17; i++) cen_pulse();
    chk("coll_pre", 5'd17, 1'b1);
    @(negedge clk);
    bus.period  = 16'd2;
    bus.cen256  = 1'b1;
    bus.restart = 1'b1;
    @(negedge clk);
    bus.cen256  = 1'b0;
    bus.restart = 1'b0;
    chk("coll_restart_wins", 5'd0, 1'b1);
    cen_pulse();
    chk("coll_first_cen", 5'd0, 1'b1);
    cen_pulse();
    chk("coll_second_cen", 5'd1, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cen_pulse();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.restart = 1'b1;
    bus.cen256  = 1'b1;
    @(negedge clk);
    rst_n       = 1'b1;
    bus.restart = 1'b0;
    bus.cen256  = 1'b0;
    chk("reset_mid", 5'd0, 1'b0);
    cen_pulse();
    chk("reset_mid_idle", 5'd0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_decay();
    test_triangle();
    test_period_zero();
    test_hold();
    test_shape_live();
    test_restart_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
